// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial frame receiver.
package serial_rx_pkg;

  localparam int unsigned DataWDefault = 8;

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} rx_state_e;

  typedef enum logic {ParityEven, ParityOdd} parity_mode_e;

  localparam parity_mode_e ParityMode = ParityEven;

  // Seed for the running XOR so that a well-formed frame leaves it at 0.
  function automatic logic parity_seed(parity_mode_e mode);
    return mode == ParityOdd;
  endfunction

endpackage

// File: rtl/serial_frame_rx_if.sv
// Output handshake bundle of the serial frame receiver.
interface serial_frame_rx_if
  import serial_rx_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault
);

  logic [DATA_W-1:0] data_out;
  logic              out_valid;
  logic              out_ready;
  logic              parity_err;

  modport master (
    output data_out,
    output out_valid,
    output parity_err,
    input  out_ready
  );

  modport slave (
    input  data_out,
    input  out_valid,
    input  parity_err,
    output out_ready
  );

endinterface

// File: rtl/rx_shift_reg.sv
// Enabled right-shifting payload register; new bits enter at the MSB.
module rx_shift_reg
  import serial_rx_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shift_i,
  input  logic              bit_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
    end else if (shift_i) begin
      data_q <= {bit_i, data_q[DATA_W-1:1]};
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start, LSB-first payload, even parity, stop; registered
// valid/ready output with overrun and framing-error reporting.
module serial_frame_rx
  import serial_rx_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ip,
  input  logic                     ip_en,
  serial_frame_rx_if.master        rx_out,
  output logic                     frame_err,
  output logic                     overrun
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

  rx_state_e state_q, state_d;

  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              par_q, par_d;
  logic [DATA_W-1:0] shift_data;
  logic              shift_en;
  logic              deliver;
  logic              accept;

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;

  rx_shift_reg #(
    .DATA_W (DATA_W)
  ) u_shift (
    .clk     (clk),
    .reset   (reset),
    .shift_i (shift_en),
    .bit_i   (ip),
    .data_o  (shift_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ip_en) begin
      case (state_q)
        StIdle:   if (!ip) state_d = StData;
        StData:   if (cnt_q == LastBit) state_d = StParity;
        StParity: state_d = StStop;
        StStop:   state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    par_d       = par_q;
    data_d      = data_q;
    valid_d     = valid_q;
    perr_d      = perr_q;
    overrun_d   = overrun_q;
    shift_en    = ip_en && (state_q == StData);
    deliver     = ip_en && (state_q == StStop) && ip;
    frame_err_d = ip_en && (state_q == StStop) && !ip;
    accept      = valid_q && rx_out.out_ready;

    if (ip_en) begin
      case (state_q)
        StIdle: begin
          if (!ip) begin
            cnt_d = '0;
            par_d = parity_seed(ParityMode);
          end
        end
        StData: begin
          cnt_d = cnt_q + 1'b1;
          par_d = par_q ^ ip;
        end
        StParity: par_d = par_q ^ ip;
        default: ;
      endcase
    end

    // A frame landing on an accepting edge replaces the outgoing one seamlessly.
    if (deliver && (!valid_q || accept)) begin
      data_d  = shift_data;
      perr_d  = par_q;
      valid_d = 1'b1;
    end else if (deliver) begin
      overrun_d = 1'b1;
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      par_q       <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      par_q       <= par_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_out.data_out   = data_q;
  assign rx_out.out_valid  = valid_q;
  assign rx_out.parity_err = perr_q;
  assign frame_err         = frame_err_q;
  assign overrun           = overrun_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: expected frames queued at send time and
// compared on each output transfer, plus directed handshake and error checks.
module tb_serial_frame_rx;

  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic reset;
  logic ip;
  logic ip_en;
  logic frame_err;
  logic overrun;

  serial_frame_rx_if #(.DATA_W(DW)) rx_if ();

  serial_frame_rx #(
    .DATA_W (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ip        (ip),
    .ip_en     (ip_en),
    .rx_out    (rx_if.master),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_bad  = 0;
  int fe_cnt = 0;
  logic [DW:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected {parity_err, data} for a frame carrying payload d and parity bit pbit.
  function automatic logic [DW:0] model(input logic [DW-1:0] d, input logic pbit);
    return {(^d) ^ pbit, d};
  endfunction

  // One clock: score any transfer happening on this edge, then move to the next negedge.
  task automatic tick();
    logic [DW:0] e;
    if (rx_if.out_valid && rx_if.out_ready) begin
      if (exp_q.size() == 0) begin
        check("xfer_expected", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("xfer_data", rx_if.data_out, e[DW-1:0]);
        check("xfer_perr", rx_if.parity_err, e[DW]);
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (frame_err) fe_cnt++;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic pbit, input logic stop,
                            input logic toggle, input logic rdy_on_stop, output int cyc);
    logic [DW+2:0] fr;
    fr  = {stop, pbit, d, 1'b0};
    cyc = 0;
    for (int i = 0; i < DW + 3; i++) begin
      if (toggle && i > 0) begin
        ip_en = 1'b0;
        ip    = ~fr[i];
        tick();
        cyc++;
      end
      ip    = fr[i];
      ip_en = 1'b1;
      if (i == DW + 2 && rdy_on_stop) rx_if.out_ready = 1'b1;
      tick();
      cyc++;
    end
    if (rdy_on_stop) rx_if.out_ready = 1'b0;
    ip = 1'b1;
  endtask

  task automatic accept();
    rx_if.out_ready = 1'b1;
    tick();
    rx_if.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int fe0;

    reset           = 1'b0;
    ip              = 1'b1;
    ip_en           = 1'b0;
    rx_if.out_ready = 1'b0;
    tick();
    tick();
    check("rst_data", rx_if.data_out, 0);
    check("rst_valid", rx_if.out_valid, 0);
    check("rst_perr", rx_if.parity_err, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    reset = 1'b1;
    ip_en = 1'b1;
    tick();

    // Clean 0xA5, correct parity.
    exp_q.push_back(model(8'hA5, 1'b0));
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, cyc);
    check("a_cycles", cyc, 11);
    check("a_valid", rx_if.out_valid, 1);
    check("a_data", rx_if.data_out, 8'hA5);
    check("a_perr", rx_if.parity_err, 0);
    tick();
    tick();
    check("a_hold_valid", rx_if.out_valid, 1);
    check("a_hold_data", rx_if.data_out, 8'hA5);
    accept();
    check("a_valid_drop", rx_if.out_valid, 0);

    // Same payload, wrong parity bit.
    exp_q.push_back(model(8'hA5, 1'b1));
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, cyc);
    check("b_data", rx_if.data_out, 8'hA5);
    check("b_perr", rx_if.parity_err, 1);
    accept();

    // Bad stop bit: one-cycle frame_err, nothing delivered.
    fe0 = fe_cnt;
    send_frame(8'h3C, ^8'h3C, 1'b0, 1'b0, 1'b0, cyc);
    check("c_ferr_pulse", frame_err, 1);
    check("c_valid", rx_if.out_valid, 0);
    tick();
    check("c_ferr_low", frame_err, 0);
    check("c_ferr_count", fe_cnt - fe0, 1);
    check("c_valid_after", rx_if.out_valid, 0);

    // Delivery coinciding with acceptance of the held frame.
    exp_q.push_back(model(8'h33, ^8'h33));
    send_frame(8'h33, ^8'h33, 1'b1, 1'b0, 1'b0, cyc);
    exp_q.push_back(model(8'h44, ^8'h44));
    send_frame(8'h44, ^8'h44, 1'b1, 1'b0, 1'b1, cyc);
    check("d_valid", rx_if.out_valid, 1);
    check("d_data", rx_if.data_out, 8'h44);
    check("d_ovr", overrun, 0);
    accept();

    // Overrun: second frame dropped while first is held.
    exp_q.push_back(model(8'h11, ^8'h11));
    send_frame(8'h11, ^8'h11, 1'b1, 1'b0, 1'b0, cyc);
    send_frame(8'h22, ^8'h22, 1'b1, 1'b0, 1'b0, cyc);
    check("e_data", rx_if.data_out, 8'h11);
    check("e_valid", rx_if.out_valid, 1);
    check("e_ovr", overrun, 1);
    accept();
    check("e_valid_drop", rx_if.out_valid, 0);
    check("e_ovr_sticky", overrun, 1);

    // ip_en toggling every cycle.
    exp_q.push_back(model(8'hA5, 1'b0));
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, cyc);
    check("f_cycles", cyc, 21);
    check("f_valid", rx_if.out_valid, 1);
    check("f_data", rx_if.data_out, 8'hA5);
    check("f_perr", rx_if.parity_err, 0);
    accept();

    // Reset after the 4th data bit aborts the frame.
    fe0   = fe_cnt;
    ip    = 1'b0;
    ip_en = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      ip = 1'b1;
      tick();
    end
    reset = 1'b0;
    tick();
    check("g_rst_valid", rx_if.out_valid, 0);
    check("g_rst_ovr", overrun, 0);
    reset = 1'b1;
    ip    = 1'b1;
    tick();
    exp_q.push_back(model(8'h5A, ^8'h5A));
    send_frame(8'h5A, ^8'h5A, 1'b1, 1'b0, 1'b0, cyc);
    check("g_valid", rx_if.out_valid, 1);
    check("g_data", rx_if.data_out, 8'h5A);
    check("g_ferr_none", fe_cnt - fe0, 0);
    accept();

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 Parameter DATA_W SHALL default to 8 and set the payload bits per frame; legal range is 4..16.
REQ-002 clk  input  1  SHALL be the single clock, with all state updating on its rising edge.
REQ-003 reset  input  1  SHALL be an asynchronous, active-low reset that clears all state immediately while low.
REQ-004 ip  input  1  SHALL carry the serial bit stream from the upstream shift-register stage.
REQ-005 ip_en  input  1  SHALL mark the bit-valid strobe, and ip SHALL be sampled only on edges where ip_en=1.
REQ-006 data_out  output  DATA_W  SHALL present the received payload, valid while out_valid=1.
REQ-007 out_valid  output  1  SHALL indicate that data_out and parity_err hold an unconsumed frame.
REQ-008 out_ready  input  1  SHALL be the consumer acceptance signal, and a transfer occurs on an edge where out_valid=1 and out_ready=1.
REQ-009 parity_err  output  1  SHALL flag an even-parity mismatch for the frame in data_out, qualified by out_valid.
REQ-010 frame_err  output  1  SHALL be a one-cycle pulse indicating a bad stop bit.
REQ-011 overrun  output  1  SHALL be a sticky flag indicating that a completed frame was dropped because the output was still full.

Function
REQ-012 Frame format SHALL be: start bit 0, then DATA_W data bits LSB first, then an even-parity bit, then stop bit 1.
REQ-013 The FSM SHALL have the states IDLE, DATA, PARITY and STOP.
REQ-014 IDLE: on a sampled ip=0 the FSM SHALL go to DATA with the bit count cleared; on a sampled ip=1 it SHALL remain in IDLE.
REQ-015 DATA: each sampled bit SHALL shift in at the MSB, shift the register right and update the running XOR; after DATA_W samples the FSM SHALL go to PARITY.
REQ-016 PARITY: the sampled bit SHALL be XORed into the running parity, and the FSM SHALL go to STOP.
REQ-017 STOP with sampled ip=1: the frame SHALL be delivered per REQ-019/020, and the FSM SHALL return to IDLE.
REQ-018 STOP with sampled ip=0: frame_err SHALL pulse for exactly the next cycle, the frame SHALL be discarded, and the FSM SHALL return to IDLE.
REQ-019 Delivery: data_out, parity_err and out_valid=1 SHALL be registered on the stop-bit edge, so out_valid is visible one cycle after that edge.
REQ-020 Delivery while out_valid=1 and out_ready=0 SHALL drop the new frame, SHALL set overrun, and SHALL leave the held frame unchanged.
REQ-021 Delivery on the same edge as an accepting transfer SHALL load the new frame, SHALL keep out_valid=1, and SHALL not set overrun.
REQ-022 A transfer with no delivery on that edge SHALL clear out_valid on the next cycle.
REQ-023 ip_en=0 SHALL freeze the FSM, counter, shift register and parity, while the output handshake remains independent of ip_en.
REQ-024 data_out SHALL hold stable while out_valid=1 and not accepted.
REQ-025 overrun SHALL clear only on reset.
REQ-026 parity_err SHALL be 1 exactly when the XOR of the data bits and the parity bit equals 1.
REQ-027 The bit counter SHALL be $clog2(DATA_W+1) bits wide and SHALL not wrap within a frame.

Reset
REQ-028 While reset=0: FSM SHALL be IDLE; counter, shift register, data_out, out_valid, parity_err, frame_err and overrun SHALL all be 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no delivery and no frame_err pulse.
REQ-030 The first ip_en edge after reset deasserts SHALL be treated as an IDLE sample.

Structure
REQ-031 Package serial_rx_pkg SHALL hold the state enum, the DATA_W default and the parity-mode constant (EVEN).
REQ-032 One sub-module, rx_shift_reg, SHALL implement the enabled, right-shifting DATA_W register with asynchronous active-low clear.
REQ-033 All outputs SHALL be registered, with no combinational path from ip to any output.

Verification
REQ-034 The bench SHALL show: ip_en=1 each cycle, frame 0,1,0,1,0,0,1,0,1,0(parity),1 -> data_out=0xA5, parity_err=0, out_valid=1 one cycle after the stop edge.
REQ-035 The bench SHALL show: same frame with parity bit 1 -> data_out=0xA5, parity_err=1.
REQ-036 The bench SHALL show: frame 0x3C with stop bit 0 -> frame_err high exactly one cycle, out_valid stays 0.
REQ-037 The bench SHALL show: out_ready=0, two frames 0x11 then 0x22 -> data_out=0x11, overrun=1; then out_ready=1 -> out_valid drops next cycle.
REQ-038 The bench SHALL show: ip_en toggling 1/0 each cycle with 0xA5 -> same result as REQ-034, with latency doubled.
REQ-039 The bench SHALL show: reset pulsed low after the 4th data bit, then a clean 0x5A frame -> 0x5A delivered, no frame_err.
